// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage of the 64-bit pipeline.
// Chooses the write-back value (load data or ALU result) and commits it to a
// 32 x XLEN integer register file. Two combinational decode read ports see
// a write-through bypass of the value being committed this cycle. A 64-bit
// counter tracks committed writes for debug and performance monitoring.
module wb_regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MWB_RegWrite,
    input  logic            MWB_MemToReg,
    input  logic [XLEN-1:0] MWB_ReadData,
    input  logic [XLEN-1:0] MWB_ALUResult,
    input  logic [4:0]      MWB_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    output logic [XLEN-1:0] WB_WriteData,
    output logic            WB_Valid,
    output logic [63:0]     RetireCount
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [63:0]     retire_q;
    logic [63:0]     retire_d;
    logic [XLEN-1:0] wb_data_s;
    logic            wb_valid_s;
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;

    // Write-back data select and commit qualifier (x0 is never a target).
    always_comb begin
        wb_data_s  = MWB_ALUResult;
        wb_valid_s = 1'b0;
        if (MWB_MemToReg) begin
            wb_data_s = MWB_ReadData;
        end else begin
            wb_data_s = MWB_ALUResult;
        end
        if (MWB_RegWrite && (MWB_rd != 5'd0)) begin
            wb_valid_s = 1'b1;
        end else begin
            wb_valid_s = 1'b0;
        end
    end

    // Next-state of the register array and the retire counter.
    always_comb begin
        regs_d   = regs_q;
        retire_d = retire_q;
        if (wb_valid_s) begin
            regs_d[MWB_rd] = wb_data_s;
            retire_d       = retire_q + 64'd1;
        end else begin
            retire_d = retire_q;
        end
    end

    // Read port A: x0 reads zero, then bypass, then array; bypass is held off in reset.
    always_comb begin
        rd1_s = {XLEN{1'b0}};
        if (!reset) begin
            rd1_s = {XLEN{1'b0}};
        end else if (rs1 == 5'd0) begin
            rd1_s = {XLEN{1'b0}};
        end else if (wb_valid_s && (MWB_rd == rs1)) begin
            rd1_s = wb_data_s;
        end else begin
            rd1_s = regs_q[rs1];
        end
    end

    // Read port B: same priority as port A, indexed by rs2.
    always_comb begin
        rd2_s = {XLEN{1'b0}};
        if (!reset) begin
            rd2_s = {XLEN{1'b0}};
        end else if (rs2 == 5'd0) begin
            rd2_s = {XLEN{1'b0}};
        end else if (wb_valid_s && (MWB_rd == rs2)) begin
            rd2_s = wb_data_s;
        end else begin
            rd2_s = regs_q[rs2];
        end
    end

    // State registers: async clear discards any pending write and zeroes all state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
            retire_q <= 64'd0;
        end else begin
            regs_q   <= regs_d;
            retire_q <= retire_d;
        end
    end

    assign ReadData1    = rd1_s;
    assign ReadData2    = rd2_s;
    assign WB_WriteData = wb_data_s;
    assign WB_Valid     = wb_valid_s;
    assign RetireCount  = retire_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed testbench for wb_regfile with hand-computed expected values.
// Inputs change on the falling edge; outputs are sampled 2 ns later.
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic        MWB_RegWrite;
    logic        MWB_MemToReg;
    logic [63:0] MWB_ReadData;
    logic [63:0] MWB_ALUResult;
    logic [4:0]  MWB_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic [63:0] WB_WriteData;
    logic        WB_Valid;
    logic [63:0] RetireCount;

    int n_vec;
    int n_bad;

    wb_regfile #(.XLEN(64), .NREGS(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .MWB_RegWrite (MWB_RegWrite),
        .MWB_MemToReg (MWB_MemToReg),
        .MWB_ReadData (MWB_ReadData),
        .MWB_ALUResult(MWB_ALUResult),
        .MWB_rd       (MWB_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .WB_WriteData (WB_WriteData),
        .WB_Valid     (WB_Valid),
        .RetireCount  (RetireCount)
    );

    // 10 ns clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset         = 1'b0;
        MWB_RegWrite  = 1'b0;
        MWB_MemToReg  = 1'b0;
        MWB_ReadData  = 64'd0;
        MWB_ALUResult = 64'd0;
        MWB_rd        = 5'd0;
        rs1           = 5'd5;
        rs2           = 5'd31;
        #3;
        check_eq("rst_rd1", ReadData1, 64'd0);
        check_eq("rst_rd2", ReadData2, 64'd0);
        check_eq("rst_rc", RetireCount, 64'd0);
        check_eq("rst_valid", {63'd0, WB_Valid}, 64'd0);

        // A write presented during reset: WB_Valid follows inputs, no bypass, no commit.
        MWB_RegWrite  = 1'b1;
        MWB_rd        = 5'd5;
        MWB_ALUResult = 64'h99;
        #1;
        check_eq("rst_valid_comb", {63'd0, WB_Valid}, 64'd1);
        check_eq("rst_no_bypass", ReadData1, 64'd0);
        @(posedge clk);
        #1;
        check_eq("rst_no_commit_rc", RetireCount, 64'd0);

        // Release reset, three idle cycles.
        next_cycle();
        MWB_RegWrite = 1'b0;
        reset        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #2;
            check_eq("idle_rd1", ReadData1, 64'd0);
            check_eq("idle_rd2", ReadData2, 64'd0);
            check_eq("idle_rc", RetireCount, 64'd0);
        end

        // ALU write to x7 with same-cycle bypass.
        next_cycle();
        MWB_RegWrite  = 1'b1;
        MWB_MemToReg  = 1'b0;
        MWB_ALUResult = 64'h0000_0000_DEAD_BEEF;
        MWB_rd        = 5'd7;
        rs1           = 5'd7;
        #2;
        check_eq("alu_bypass_rd1", ReadData1, 64'h0000_0000_DEAD_BEEF);
        check_eq("alu_wbdata", WB_WriteData, 64'h0000_0000_DEAD_BEEF);
        check_eq("alu_valid", {63'd0, WB_Valid}, 64'd1);
        next_cycle();
        MWB_RegWrite = 1'b0;
        #2;
        check_eq("alu_array_rd1", ReadData1, 64'h0000_0000_DEAD_BEEF);
        check_eq("alu_rc", RetireCount, 64'd1);

        // Load select, both ports on the register being written.
        MWB_RegWrite  = 1'b1;
        MWB_MemToReg  = 1'b1;
        MWB_ReadData  = 64'hFFFF_FFFF_FFFF_FFF0;
        MWB_ALUResult = 64'h1234;
        MWB_rd        = 5'd3;
        rs1           = 5'd3;
        rs2           = 5'd3;
        #2;
        check_eq("ld_rd1", ReadData1, 64'hFFFF_FFFF_FFFF_FFF0);
        check_eq("ld_rd2", ReadData2, 64'hFFFF_FFFF_FFFF_FFF0);
        check_eq("ld_wbdata", WB_WriteData, 64'hFFFF_FFFF_FFFF_FFF0);
        next_cycle();
        MWB_RegWrite = 1'b0;
        MWB_MemToReg = 1'b0;
        #2;
        check_eq("ld_array_rd1", ReadData1, 64'hFFFF_FFFF_FFFF_FFF0);
        check_eq("ld_array_rd2", ReadData2, 64'hFFFF_FFFF_FFFF_FFF0);
        check_eq("ld_rc", RetireCount, 64'd2);

        // x0 protection for four cycles.
        MWB_RegWrite  = 1'b1;
        MWB_MemToReg  = 1'b0;
        MWB_ALUResult = 64'h55;
        MWB_rd        = 5'd0;
        rs1           = 5'd0;
        rs2           = 5'd7;
        for (int i = 0; i < 4; i++) begin
            #2;
            check_eq("x0_rd1", ReadData1, 64'd0);
            check_eq("x0_valid", {63'd0, WB_Valid}, 64'd0);
            next_cycle();
        end
        MWB_RegWrite = 1'b0;
        #2;
        check_eq("x0_after_rd1", ReadData1, 64'd0);
        check_eq("x0_after_rd2", ReadData2, 64'h0000_0000_DEAD_BEEF);
        check_eq("x0_rc", RetireCount, 64'd2);

        // Disabled write to x9.
        MWB_RegWrite  = 1'b0;
        MWB_rd        = 5'd9;
        MWB_ALUResult = 64'hAA;
        rs2           = 5'd9;
        #2;
        check_eq("dis_rd2", ReadData2, 64'd0);
        check_eq("dis_wbdata", WB_WriteData, 64'hAA);
        check_eq("dis_valid", {63'd0, WB_Valid}, 64'd0);
        next_cycle();
        #2;
        check_eq("dis_after_rd2", ReadData2, 64'd0);
        check_eq("dis_rc", RetireCount, 64'd2);

        // Bypass overrides stale array content on one port only.
        MWB_RegWrite  = 1'b1;
        MWB_ALUResult = 64'h1111;
        MWB_rd        = 5'd7;
        rs1           = 5'd7;
        rs2           = 5'd3;
        #2;
        check_eq("ovr_rd1", ReadData1, 64'h1111);
        check_eq("ovr_rd2", ReadData2, 64'hFFFF_FFFF_FFFF_FFF0);
        next_cycle();
        MWB_RegWrite = 1'b0;
        #2;
        check_eq("ovr_array_rd1", ReadData1, 64'h1111);
        check_eq("ovr_rc", RetireCount, 64'd3);

        // Async reset mid-stream.
        MWB_RegWrite  = 1'b1;
        MWB_ALUResult = 64'h77;
        MWB_rd        = 5'd4;
        rs1           = 5'd4;
        rs2           = 5'd7;
        next_cycle();
        MWB_RegWrite = 1'b0;
        #2;
        check_eq("ar_x4_77", ReadData1, 64'h77);
        check_eq("ar_rc4", RetireCount, 64'd4);
        MWB_RegWrite  = 1'b1;
        MWB_ALUResult = 64'h88;
        #1;
        check_eq("ar_bypass_88", ReadData1, 64'h88);
        reset = 1'b0;
        #1;
        check_eq("ar_x4_zero", ReadData1, 64'd0);
        check_eq("ar_x7_zero", ReadData2, 64'd0);
        check_eq("ar_rc_zero", RetireCount, 64'd0);
        next_cycle();
        MWB_RegWrite = 1'b0;
        reset        = 1'b1;
        #2;
        check_eq("ar_rel_x4", ReadData1, 64'd0);
        check_eq("ar_rel_rc", RetireCount, 64'd0);
        next_cycle();
        #2;
        check_eq("ar_idle_x4", ReadData1, 64'd0);
        MWB_RegWrite  = 1'b1;
        MWB_ALUResult = 64'h42;
        next_cycle();
        MWB_RegWrite = 1'b0;
        #2;
        check_eq("ar_new_x4", ReadData1, 64'h42);
        check_eq("ar_new_rc", RetireCount, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
